// File: rtl/cmac_slcg_pkg.sv
// Shared definitions for the CMAC core second-level clock-gating enable control.
// Holds the gating FSM state encoding, default parameter values and the legal
// wake-latency window used to clamp out-of-range WAKE_LAT settings.
package cmac_slcg_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } slcg_state_t;

    localparam int SLCG_CNT_W_DEF    = 8;
    localparam int SLCG_WAKE_LAT_DEF = 2;
    localparam int SLCG_WAKE_LAT_MIN = 1;
    localparam int SLCG_WAKE_LAT_MAX = 15;

    // Force an out-of-range wake latency back into the legal window so the
    // counter load value can never underflow or exceed its intended range.
    function automatic int clamp_wake_lat(input int lat);
        if (lat < SLCG_WAKE_LAT_MIN) return SLCG_WAKE_LAT_MIN;
        if (lat > SLCG_WAKE_LAT_MAX) return SLCG_WAKE_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/cmac_slcg_en_ctrl_sync2.sv
// 1-bit two-flop synchroniser for asynchronous clock-override levels.
// Latency: 2 cycles. No backpressure (level signal).
// Both flops clear on synchronous active-high reset.
module cmac_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmac_slcg_en_ctrl.sv
// Derives the CMAC core SLCG enables from activity with an idle hold-off and a wake handshake.
// Latency: enables are registered from next state (1 cycle); override syncs are 2 cycles.
// Backpressure: wake_ack low tells upstream (CSC) not to issue until the core clock is stable.
// Optional macro CMAC_SLCG_GATED_CNT_EN adds the 32-bit gated_cycles saturating counter.
module cmac_slcg_en_ctrl
    import cmac_slcg_pkg::*;
#(
    parameter int CNT_W    = SLCG_CNT_W_DEF,
    parameter int WAKE_LAT = SLCG_WAKE_LAT_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             op_en,
    input  logic             in_activity,
    input  logic             out_activity,
    input  logic             wake_req,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic             tmc2slcg_disable_clock_gating,
    input  logic             dla_clk_ovr_on,
    input  logic             global_clk_ovr_on,
    output logic             slcg_en_src_0,
    output logic             slcg_en_src_1,
    output logic             wake_ack,
    output logic             dla_clk_ovr_on_sync,
    output logic             global_clk_ovr_on_sync
`ifdef CMAC_SLCG_GATED_CNT_EN
    ,
    output logic [31:0]      gated_cycles
`endif
);

    localparam int               WAKE_LAT_EFF  = clamp_wake_lat(WAKE_LAT);
    localparam logic [CNT_W-1:0] WAKE_CNT_INIT = CNT_W'(WAKE_LAT_EFF - 1);

    slcg_state_t      state;
    slcg_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovr;
    logic             busy;

    cmac_sync2 u_dla_sync (
        .clk (nvdla_core_clk),
        .rst (nvdla_core_rst),
        .d   (dla_clk_ovr_on),
        .q   (dla_clk_ovr_on_sync)
    );

    cmac_sync2 u_global_sync (
        .clk (nvdla_core_clk),
        .rst (nvdla_core_rst),
        .d   (global_clk_ovr_on),
        .q   (global_clk_ovr_on_sync)
    );

    // Any override forces the clock on; in_activity counts as busy even when
    // it arrives illegally during WAKE so the clock is never gated under data.
    assign ovr  = dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;
    assign busy = wake_req | in_activity | out_activity | ovr;

    // Next-state and counter update; busy always wins over an expiring hold-off.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (!busy && (cfg_holdoff != '0)) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = cfg_holdoff - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (busy) begin
                    state_nxt = ST_RUN;
                end else if (cnt == '0) begin
                    state_nxt = ST_GATED;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (busy) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = WAKE_CNT_INIT;
                end
            end
            ST_WAKE: begin
                // Fixed-length settle window; nothing may shorten it.
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register plus enables registered from the next state for a clean gate input.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state         <= ST_RUN;
            cnt           <= '0;
            slcg_en_src_0 <= 1'b0;
            slcg_en_src_1 <= 1'b1;
            wake_ack      <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            slcg_en_src_0 <= op_en | out_activity;
            slcg_en_src_1 <= (state_nxt != ST_GATED);
            wake_ack      <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
        end
    end

`ifdef CMAC_SLCG_GATED_CNT_EN
    logic op_en_q;

    // Saturating count of gated cycles, restarted at each new layer (op_en rise).
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            op_en_q      <= 1'b0;
            gated_cycles <= '0;
        end else begin
            op_en_q <= op_en;
            if (op_en && !op_en_q) begin
                gated_cycles <= '0;
            end else if (!slcg_en_src_1 && (gated_cycles != 32'hFFFF_FFFF)) begin
                gated_cycles <= gated_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
